// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of the single-ported system RAM (CPU control unit vs. DMA).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module ram_arbiter #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_rd,
    input  logic        dma_wr,
    output logic [15:0] dma_rdata,
    output logic        dma_ready,
    output logic [15:0] ram_address_in,
    output logic [15:0] ram_data_out,
    output logic        ram_read_en,
    output logic        ram_write_en,
    input  logic [15:0] ram_data_in,
    output logic        grant_dma,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [2:0] LatInit = 3'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;  // 1 = DMA
    logic        grant_dma_q, grant_dma_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        read_en_q, read_en_d;
    logic        write_en_q, write_en_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dma_ready_q, dma_ready_d;
    logic        busy_q, busy_d;

    logic cpu_req, dma_req, pick_dma, pick_wr;

    assign cpu_req = cpu_rd | cpu_wr;
    assign dma_req = dma_rd | dma_wr;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // On a tie the DMA wins only if the CPU was served last.
    assign pick_dma = dma_req & (~cpu_req | ~last_grant_q);
`else
    assign pick_dma = dma_req & ~cpu_req;
`endif

    // A simultaneous rd+wr on one port is treated as a write.
    assign pick_wr = pick_dma ? dma_wr : cpu_wr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_dma_d  = grant_dma_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        read_en_d    = 1'b0;
        write_en_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        cpu_ready_d  = 1'b0;
        dma_ready_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req || dma_req) begin
                    grant_dma_d  = pick_dma;
                    last_grant_d = pick_dma;
                    addr_d       = pick_dma ? dma_addr : cpu_addr;
                    wdata_d      = pick_dma ? dma_wdata : cpu_wdata;
                    if (pick_wr) begin
                        write_en_d = 1'b1;
                        state_d    = StWrite;
                    end else begin
                        read_en_d = 1'b1;
                        cnt_d     = LatInit;
                        state_d   = StRead;
                    end
                end
            end
            StRead: begin
                if (cnt_q == 3'd0) begin
                    if (grant_dma_q) begin
                        dma_rdata_d = ram_data_in;
                        dma_ready_d = 1'b1;
                    end else begin
                        cpu_rdata_d = ram_data_in;
                        cpu_ready_d = 1'b1;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWrite: begin
                dma_ready_d = grant_dma_q;
                cpu_ready_d = ~grant_dma_q;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            grant_dma_q  <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            cpu_rdata_q  <= 16'h0000;
            dma_rdata_q  <= 16'h0000;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_dma_q  <= grant_dma_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            read_en_q    <= read_en_d;
            write_en_q   <= write_en_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            dma_ready_q  <= dma_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_address_in = addr_q;
    assign ram_data_out   = wdata_q;
    assign ram_read_en    = read_en_q;
    assign ram_write_en   = write_en_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign dma_rdata      = dma_rdata_q;
    assign cpu_ready      = cpu_ready_q;
    assign dma_ready      = dma_ready_q;
    assign grant_dma      = grant_dma_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (read latency 1 and 3), each with a RAM model that only
// presents valid data in the cycle before the capture edge, checked against a transaction model.
module tb_ram_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic [15:0] cpu_addr [2], cpu_wdata [2], dma_addr [2], dma_wdata [2], ram_data_in [2];
    logic        cpu_rd [2], cpu_wr [2], dma_rd [2], dma_wr [2];
    logic [15:0] cpu_rdata [2], dma_rdata [2], ram_address_in [2], ram_data_out [2];
    logic        cpu_ready [2], dma_ready [2], ram_read_en [2], ram_write_en [2];
    logic        grant_dma [2], busy [2];

    ram_arbiter #(.READ_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]),
        .cpu_rdata(cpu_rdata[0]), .cpu_ready(cpu_ready[0]),
        .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]), .dma_rd(dma_rd[0]), .dma_wr(dma_wr[0]),
        .dma_rdata(dma_rdata[0]), .dma_ready(dma_ready[0]),
        .ram_address_in(ram_address_in[0]), .ram_data_out(ram_data_out[0]),
        .ram_read_en(ram_read_en[0]), .ram_write_en(ram_write_en[0]),
        .ram_data_in(ram_data_in[0]), .grant_dma(grant_dma[0]), .busy(busy[0])
    );

    ram_arbiter #(.READ_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]),
        .cpu_rdata(cpu_rdata[1]), .cpu_ready(cpu_ready[1]),
        .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]), .dma_rd(dma_rd[1]), .dma_wr(dma_wr[1]),
        .dma_rdata(dma_rdata[1]), .dma_ready(dma_ready[1]),
        .ram_address_in(ram_address_in[1]), .ram_data_out(ram_data_out[1]),
        .ram_read_en(ram_read_en[1]), .ram_write_en(ram_write_en[1]),
        .ram_data_in(ram_data_in[1]), .grant_dma(grant_dma[1]), .busy(busy[1])
    );

    int vectors = 0;
    int miscompares = 0;

    // RAM contents (written by the DUT) and the bench's own expectation of them.
    bit   [15:0] mem [2][65536];
    bit          wrt [2][65536];
    bit   [15:0] exp_mem [2][65536];
    bit          exp_wrt [2][65536];
    logic [15:0] exp_rdata [2][2];

    // Chosen so that address 0x0100 holds 0x1234 before any write.
    function automatic logic [15:0] init_val(logic [15:0] a);
        return a ^ 16'h1334;
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [15:0] ram_word(int d, logic [15:0] a);
        return wrt[d][a] ? mem[d][a] : init_val(a);
    endfunction

    function automatic logic [15:0] exp_word(int d, logic [15:0] a);
        return exp_wrt[d][a] ? exp_mem[d][a] : init_val(a);
    endfunction

    function automatic logic [15:0] pick_addr();
        logic [3:0] hi;
        hi = 4'($urandom_range(0, 15));
        return {hi, 12'h042};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_ram
        int unsigned age;
        logic        ok;
        always @(posedge clk) begin
            if (rst[g]) age <= 0;
            else if (ram_read_en[g]) age <= 1;
            else if (age != 0 && age < 8) age <= age + 1;
            if (ram_write_en[g]) begin
                mem[g][ram_address_in[g]] <= ram_data_out[g];
                wrt[g][ram_address_in[g]] <= 1'b1;
            end
        end
        // Data valid only in the cycle ending at the READ_LATENCY-th edge after the strobe.
        always_comb begin
            ok = (ram_read_en[g] && lat_of(g) == 1) ||
                 (age != 0 && age == unsigned'(lat_of(g) - 1));
            ram_data_in[g] = ok ? ram_word(g, ram_address_in[g]) : ~ram_word(g, ram_address_in[g]);
        end
    end

    task automatic set_req(int d, bit p, logic rd, logic wr, logic [15:0] a, logic [15:0] w);
        if (p) begin
            dma_rd[d] = rd; dma_wr[d] = wr; dma_addr[d] = a; dma_wdata[d] = w;
        end else begin
            cpu_rd[d] = rd; cpu_wr[d] = wr; cpu_addr[d] = a; cpu_wdata[d] = w;
        end
    endtask

    task automatic do_reset(int d);
        @(negedge clk);
        rst[d] = 1'b1;
        set_req(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(d, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); @(negedge clk);
        rst[d] = 1'b0;
        exp_rdata[d][0] = 16'h0;
        exp_rdata[d][1] = 16'h0;
    endtask

    // One complete transaction from one port with the other port idle.
    task automatic do_txn(int d, bit p, logic rd, logic wr, logic [15:0] a, logic [15:0] w);
        int n = 0, rd_hi = 0, wr_hi = 0, bad_strobe = 0, bad_busy = 0, other_rdy = 0;
        int exp_n;
        bit done = 0;
        bit is_wr = wr;
        exp_n = is_wr ? 2 : lat_of(d) + 1;
        @(negedge clk);
        set_req(d, p, rd, wr, a, w);
        while (!done && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (ram_read_en[d]) rd_hi++;
            if (ram_write_en[d]) wr_hi++;
            if ((ram_read_en[d] || ram_write_en[d]) &&
                (ram_address_in[d] !== a || grant_dma[d] !== p ||
                 (is_wr && ram_data_out[d] !== w))) bad_strobe++;
            if (busy[d] !== 1'b1) bad_busy++;
            if (p ? cpu_ready[d] : dma_ready[d]) other_rdy++;
            if (p ? dma_ready[d] : cpu_ready[d]) done = 1;
        end
        set_req(d, p, 1'b0, 1'b0, a, w);
        if (is_wr) begin
            exp_mem[d][a] = w;
            exp_wrt[d][a] = 1'b1;
        end else begin
            exp_rdata[d][p] = exp_word(d, a);
        end
        vectors++;
        if (n !== exp_n || !done) begin
            miscompares++;
            $display("FAIL latency d%0d p%0d a=%h: got %0d edges (done=%0d) want %0d",
                     d, p, a, n, done, exp_n);
        end
        vectors++;
        if (rd_hi !== (is_wr ? 0 : 1) || wr_hi !== (is_wr ? 1 : 0)) begin
            miscompares++;
            $display("FAIL strobe_count d%0d p%0d: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                     d, p, rd_hi, wr_hi, is_wr ? 0 : 1, is_wr ? 1 : 0);
        end
        vectors++;
        if (bad_strobe !== 0 || bad_busy !== 0 || other_rdy !== 0) begin
            miscompares++;
            $display("FAIL strobe_fields d%0d p%0d: got bad_strobe=%0d bad_busy=%0d other_ready=%0d want 0/0/0",
                     d, p, bad_strobe, bad_busy, other_rdy);
        end
        vectors++;
        if (cpu_rdata[d] !== exp_rdata[d][0] || dma_rdata[d] !== exp_rdata[d][1]) begin
            miscompares++;
            $display("FAIL rdata d%0d: got cpu=%h dma=%h want cpu=%h dma=%h",
                     d, cpu_rdata[d], dma_rdata[d], exp_rdata[d][0], exp_rdata[d][1]);
        end
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({cpu_ready[d], dma_ready[d], busy[d], ram_read_en[d], ram_write_en[d]} !== 5'b0) begin
            miscompares++;
            $display("FAIL back_to_idle d%0d: got rdy=%b%b busy=%b strobes=%b%b want all 0",
                     d, cpu_ready[d], dma_ready[d], busy[d], ram_read_en[d], ram_write_en[d]);
        end
    endtask

    task automatic test_reset(int d);
        @(negedge clk);
        rst[d] = 1'b1;
        set_req(d, 1'b0, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
        set_req(d, 1'b1, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ram_address_in[d], ram_data_out[d], cpu_rdata[d], dma_rdata[d]} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data d%0d: got %h %h %h %h want all 0", d,
                     ram_address_in[d], ram_data_out[d], cpu_rdata[d], dma_rdata[d]);
        end
        vectors++;
        if ({ram_read_en[d], ram_write_en[d], cpu_ready[d], dma_ready[d], grant_dma[d], busy[d]}
            !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl d%0d: got %b%b%b%b%b%b want 000000", d, ram_read_en[d],
                     ram_write_en[d], cpu_ready[d], dma_ready[d], grant_dma[d], busy[d]);
        end
        do_reset(d);
    endtask

    task automatic test_basic(int d);
        do_txn(d, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);        // CPU read, RAM holds 0x1234
        vectors++;
        if (cpu_rdata[d] !== 16'h1234) begin
            miscompares++;
            $display("FAIL cpu_read_0100 d%0d: got %h want 1234", d, cpu_rdata[d]);
        end
        do_txn(d, 1'b1, 1'b0, 1'b1, 16'h8000, 16'hBEEF);     // DMA write
        do_txn(d, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0);        // DMA read-back
        vectors++;
        if (dma_rdata[d] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL dma_readback d%0d: got %h want beef", d, dma_rdata[d]);
        end
    endtask

    task automatic test_rd_wr_both(int d);
        logic [15:0] w = 16'($urandom);
        do_txn(d, 1'b0, 1'b1, 1'b1, 16'h3042, w);
        do_txn(d, 1'b1, 1'b1, 1'b0, 16'h3042, 16'h0);
    endtask

    task automatic test_arbitration(int d);
        bit exp_order [8];
        bit got [$];
        int rc = 4, rdn = 4, cyc = 0, sc = 0, sd = 0;
        bit last = 1'b1;
        bit raise_c = 0, raise_d = 0;
        logic [15:0] ca, da;
        for (int k = 0; k < 8; k++) begin
            bit w;
            if (rc > 0 && rdn > 0) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                w = ~last;
`else
                w = 1'b0;
`endif
            end else begin
                w = (rdn > 0);
            end
            exp_order[k] = w;
            last = w;
            if (w) rdn--; else rc--;
        end
        do_reset(d);
        @(negedge clk);
        ca = pick_addr(); da = pick_addr();
        set_req(d, 1'b0, 1'b1, 1'b0, ca, 16'h0);
        set_req(d, 1'b1, 1'b1, 1'b0, da, 16'h0);
        while (got.size() < 8 && cyc < 200) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (raise_c) begin ca = pick_addr(); set_req(d, 1'b0, 1'b1, 1'b0, ca, 16'h0); raise_c = 0; end
            if (raise_d) begin da = pick_addr(); set_req(d, 1'b1, 1'b1, 1'b0, da, 16'h0); raise_d = 0; end
            if (cpu_ready[d]) begin
                got.push_back(1'b0);
                exp_rdata[d][0] = exp_word(d, ca);
                vectors++;
                if (cpu_rdata[d] !== exp_rdata[d][0] || grant_dma[d] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL arb_cpu_read d%0d: got %h grant_dma=%b want %h grant_dma=0",
                             d, cpu_rdata[d], grant_dma[d], exp_rdata[d][0]);
                end
                set_req(d, 1'b0, 1'b0, 1'b0, ca, 16'h0);
                sc++;
                if (sc < 4) raise_c = 1;
            end
            if (dma_ready[d]) begin
                got.push_back(1'b1);
                exp_rdata[d][1] = exp_word(d, da);
                vectors++;
                if (dma_rdata[d] !== exp_rdata[d][1] || grant_dma[d] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL arb_dma_read d%0d: got %h grant_dma=%b want %h grant_dma=1",
                             d, dma_rdata[d], grant_dma[d], exp_rdata[d][1]);
                end
                set_req(d, 1'b1, 1'b0, 1'b0, da, 16'h0);
                sd++;
                if (sd < 4) raise_d = 1;
            end
        end
        set_req(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(d, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        vectors++;
        if (got.size() !== 8) begin
            miscompares++;
            $display("FAIL arb_count d%0d: got %0d grants want 8", d, got.size());
        end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            vectors++;
            if (got[k] !== exp_order[k]) begin
                miscompares++;
                $display("FAIL arb_order d%0d #%0d: got grant_dma=%b want %b", d, k, got[k],
                         exp_order[k]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort(int d);
        int rdy = 0;
        do_reset(d);
        @(negedge clk);
        set_req(d, 1'b0, 1'b0, 1'b1, 16'hFFF0, 16'($urandom));
        @(posedge clk); @(negedge clk);
        vectors++;
        if (ram_write_en[d] !== 1'b1 || ram_read_en[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_granted d%0d: got wr=%b rd=%b want wr=1 rd=0", d,
                     ram_write_en[d], ram_read_en[d]);
        end
        rst[d] = 1'b1;
        set_req(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({ram_address_in[d], ram_data_out[d], cpu_rdata[d], dma_rdata[d], ram_read_en[d],
             ram_write_en[d], cpu_ready[d], dma_ready[d], grant_dma[d], busy[d]} !== 70'h0) begin
            miscompares++;
            $display("FAIL abort_reset d%0d: got addr=%h wd=%h str=%b%b rdy=%b%b g=%b busy=%b want 0",
                     d, ram_address_in[d], ram_data_out[d], ram_read_en[d], ram_write_en[d],
                     cpu_ready[d], dma_ready[d], grant_dma[d], busy[d]);
        end
        rst[d] = 1'b0;
        exp_rdata[d][0] = 16'h0;
        exp_rdata[d][1] = 16'h0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ready[d]) rdy++;
        end
        vectors++;
        if (rdy !== 0) begin
            miscompares++;
            $display("FAIL abort_no_ready d%0d: got %0d pulses want 0", d, rdy);
        end
        do_txn(d, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);
    endtask

    task automatic test_random(int d);
        for (int i = 0; i < 40; i++) begin
            bit p = 1'($urandom);
            int kind = $urandom_range(0, 2);
            do_txn(d, p, kind != 1, kind != 0, pick_addr(), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            set_req(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            set_req(d, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        for (int d = 0; d < 2; d++) begin
            test_reset(d);
            test_basic(d);
            test_rd_wr_both(d);
            test_arbitration(d);
            test_abort(d);
            test_random(d);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-ported system RAM between the CPU control unit and a secondary bus master (DMA/video fetcher). It sits between both masters and the RAM's address, data and enable pins. It accepts level-held read/write requests and grants one transaction at a time. It returns read data with a one-cycle ready pulse, and drives registered RAM enables with the same timing the control unit uses when talking to RAM directly.

## Interface
- READ_LATENCY, 1: edges between asserting ram_read_en and ram_data_in being valid (1..7).
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- cpu_addr  in  16  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_rd  in  1  CPU read request (level).
- cpu_wr  in  1  CPU write request (level).
- cpu_rdata  out  16  CPU read data, held until next CPU read completes.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- dma_addr, dma_wdata, dma_rd, dma_wr, dma_rdata, dma_ready: same as the cpu_* ports, for the DMA master.
- ram_address_in  out  16  RAM address.
- ram_data_out  out  16  RAM write data.
- ram_read_en  out  1  RAM read strobe.
- ram_write_en  out  1  RAM write strobe.
- ram_data_in  in  16  RAM read data.
- grant_dma  out  1  1 while the current/last transaction belongs to DMA.
- busy  out  1  1 in any state other than IDLE.

## Operation
- States: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE: a port is requesting if its rd or wr is high. If rd and wr are both high on one port, the request is treated as a write.
  - One port requesting: grant it.
  - Both requesting: choose per Configuration.
  - On grant: load ram_address_in and ram_data_out from the granted port, set grant_dma, and record last_grant.
  - Read: ram_read_en<=1, latency counter<=READ_LATENCY-1, go to READ.
  - Write: ram_write_en<=1, go to WRITE.
- READ:
  - ram_read_en drops on the first edge in READ.
  - When the counter is 0: capture ram_data_in into the granted port's rdata, pulse its ready, go to DONE.
  - Otherwise decrement the counter.
- WRITE: ram_write_en<=0, ready pulse to the granted port, go to DONE.
- DONE: ready<=0, go to IDLE. Requests are not sampled in DONE. The requester must drop rd/wr in the cycle its ready is high.
- The non-granted port's rdata and ready are untouched.
- The 3-bit latency counter does not wrap, because READ_LATENCY is 1..7.

## Timing
- Read, READ_LATENCY=1:
  - Edge E0 (IDLE, request seen): ram_read_en=1.
  - E1: data captured, ram_read_en=0, ready=1.
  - E2: ready=0, IDLE.
  - E3: earliest next grant.
- Read latency from request sampled to ready visible is READ_LATENCY+1 edges.
- Write: E0 ram_write_en=1; E1 ram_write_en=0, ready=1; E2 IDLE. Throughput is one write per 3 cycles.
- ram_write_en and ram_read_en are never high together. Each strobe is high for exactly one cycle per transaction.
- Reset values: ram_address_in=0, ram_data_out=0, ram_read_en=0, ram_write_en=0, cpu_rdata=0, dma_rdata=0, cpu_ready=0, dma_ready=0, grant_dma=0, busy=0, state IDLE, last_grant=DMA.
- rst mid-transaction aborts it: strobes go to 0 on that edge, no ready pulse is issued, and the aborted transaction's data is discarded.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port that was not last_grant. After reset the CPU wins first.
- Undefined: the CPU always wins simultaneous requests (fixed priority); last_grant is still tracked but unused.

## Test plan
- Reset then CPU read of 0x0100, RAM returning 0x1234, READ_LATENCY=1 -> ram_read_en high exactly one cycle with address 0x0100; cpu_ready pulses 2 edges after the request; cpu_rdata=0x1234; dma_ready stays 0.
- DMA write 0xBEEF to 0x8000 -> ram_write_en one cycle, ram_data_out=0xBEEF, grant_dma=1, dma_ready pulse on the next edge.
- CPU and DMA reads held simultaneously for 4 transactions each:
  - With RAM_ARB_ROUND_ROBIN_EN: grants alternate CPU, DMA, CPU, DMA.
  - Without it: all 4 CPU grants precede the first DMA grant.
- READ_LATENCY=3, DMA read -> data captured on the 3rd edge after the strobe; dma_ready 4 edges after the request; busy high throughout.
- rst asserted on the edge after a CPU write is granted -> both strobes 0, cpu_ready never pulses, all outputs at reset values, and the next CPU request is served normally.
- cpu_rd and cpu_wr both high -> a write is performed (ram_write_en=1, ram_read_en=0).
